// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pkg
//  Brief    : Shared encodings and defaults for the multi-cycle shifter.
//             Operation codes, FSM state codes and default widths.
//  Revision : 1.0  initial release
// ============================================================================
package shift_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int SHAMT_W_DEF = 5;

   // Operation encodings (op input)
   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_ROTR = 2'b11;

   // FSM state encodings
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // Width of the per-cycle shift count, which ranges over 0..step
   function automatic int step_cnt_w(input int step);
      return $clog2(step + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
//  Module   : shift_step
//  Brief    : Combinational single-step shifter, acc -> acc shifted by k.
//             Macro SHIFT_ROTR_EN: when defined op=11 rotates right,
//             otherwise op=11 behaves as a logical right shift.
//  Revision : 1.0  initial release
// ============================================================================
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int KW    = 1
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [1:0]       op,
   input  logic [KW-1:0]    k,
   output logic [WIDTH-1:0] acc_next
);

   // Select the shift flavour; SRA replicates the sign bit, others fill zero
   always_comb begin
      acc_next = acc;
      case (op)
         OP_SLL:  acc_next = acc << k;
         OP_SRL:  acc_next = acc >> k;
         OP_SRA:  acc_next = $unsigned($signed(acc) >>> k);
`ifdef SHIFT_ROTR_EN
         // Shifting left by WIDTH when k==0 yields zero, so k==0 is a no-op
         OP_ROTR: acc_next = (acc >> k) | (acc << (WIDTH - int'(k)));
`else
         OP_ROTR: acc_next = acc >> k;
`endif
         default: acc_next = acc;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_unit
//  Brief    : Multi-cycle shifter (SLL/SRL/SRA, optional ROTR), shifting up
//             to STEP bits per cycle with a start/busy/done handshake.
//             Optional feature macro: SHIFT_ROTR_EN (see shift_step).
//  Revision : 1.0  initial release
// ============================================================================
module seq_shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF,
   parameter int STEP    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [31:0]      shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int               KW     = step_cnt_w(STEP);
   localparam logic [SHAMT_W-1:0] c_step = SHAMT_W'(STEP);

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_result;
   logic [SHAMT_W-1:0] r_rem;
   logic [1:0]         r_op;
   logic [KW-1:0]      w_k;
   logic [SHAMT_W-1:0] w_rem_next;
   logic [SHAMT_W-1:0] w_shamt;
   logic [WIDTH-1:0]   w_acc_step;
   logic               w_accept;
   logic               w_last;
   logic               w_unused_shamt;

   // Upper shift-amount bits are architecturally ignored
   assign w_unused_shamt = ^shamt[31:SHAMT_W];
   assign w_shamt        = shamt[SHAMT_W-1:0];

   // Step size is min(STEP, rem) so rem can never underflow
   assign w_k        = KW'((r_rem < c_step) ? r_rem : c_step);
   assign w_rem_next = r_rem - SHAMT_W'(w_k);
   assign w_last     = (w_rem_next == '0);
   assign w_accept   = (r_state == S_IDLE) && start;

   shift_step #(
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_step (
      .acc      (r_acc),
      .op       (r_op),
      .k        (w_k),
      .acc_next (w_acc_step)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic; a zero shift goes straight to DONE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = (w_shamt == '0) ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   // Datapath: operands latched on acceptance, result loaded on DONE entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_rem    <= '0;
         r_op     <= OP_SLL;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_acc <= data_in;
            r_rem <= w_shamt;
            r_op  <= op;
            if (w_shamt == '0) r_result <= data_in;
         end else if (r_state == S_SHIFT) begin
            r_acc <= w_acc_step;
            r_rem <= w_rem_next;
            if (w_last) r_result <= w_acc_step;
         end
      end
   end

   assign result = r_result;

endmodule
`default_nettype wire
